// File: rtl/sas_serial_feeder.sv
// Feed stage for the ADD_SEQ shift-add sequencer: accepts a word (and optional
// coefficient), runs LOAD / SHIFT x DATA_W / DRAIN, then presents the captured result.
module sas_serial_feeder #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              DataValid,
  input  logic [DATA_W-1:0] CoeffIn,
  input  logic              CoeffValid,
  output logic              Ready,
  output logic              ParaLoad,
  output logic [DATA_W-1:0] CoeffData,
  output logic              SerialIn,
  output logic              EnableShiftAdd,
  input  logic [DATA_W-1:0] ResultIn,
  output logic [DATA_W-1:0] ResultOut,
  output logic              ResultValid,
  output logic              Busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] coeff_reg, coeff_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              loaded_reg, loaded_next;
  logic              head_bit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      coeff_reg  <= '0;
      result_reg <= '0;
      loaded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      coeff_reg  <= coeff_next;
      result_reg <= result_next;
      loaded_reg <= loaded_next;
    end
  end

  assign head_bit = LSB_FIRST ? shift_reg[0] : shift_reg[DATA_W-1];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    coeff_next     = coeff_reg;
    result_next    = result_reg;
    loaded_next    = loaded_reg;
    Ready          = 1'b0;
    ParaLoad       = 1'b0;
    SerialIn       = 1'b0;
    EnableShiftAdd = 1'b0;
    ResultValid    = 1'b0;
    Busy           = (state_reg != IDLE);
    CoeffData      = coeff_reg;
    ResultOut      = result_reg;

    case (state_reg)
      IDLE: begin
        Ready = 1'b1;
        if (DataValid) begin
          shift_next = DataIn;
          cnt_next   = '0;
          if (CoeffValid) coeff_next = CoeffIn;
          // A reset clears loaded_reg, so the first word afterwards always reloads.
          state_next = (CoeffValid || !loaded_reg) ? LOAD : SHIFT;
        end
      end
      LOAD: begin
        ParaLoad    = 1'b1;
        loaded_next = 1'b1;
        state_next  = SHIFT;
      end
      SHIFT: begin
        EnableShiftAdd = 1'b1;
        SerialIn       = head_bit;
        shift_next     = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
        if (cnt_reg == LAST_BIT) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        result_next = ResultIn;
        state_next  = DONE;
      end
      DONE: begin
        ResultValid = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Strobes read low for the whole cycle in which Reset is held.
    if (Reset) begin
      Ready          = 1'b0;
      ParaLoad       = 1'b0;
      SerialIn       = 1'b0;
      EnableShiftAdd = 1'b0;
      ResultValid    = 1'b0;
      Busy           = 1'b0;
      CoeffData      = '0;
    end
  end

endmodule

// File: tb/tb_sas_serial_feeder.sv
// Scoreboard bench: stimulus pushes expected ParaLoad/SerialIn/ResultValid events with
// their cycle stamps; a negedge monitor pops and compares them as the DUT emits them.
module tb_sas_serial_feeder;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] DataIn = '0, CoeffIn = '0, DataIn_m = '0, CoeffIn_m = '0;
  logic       DataValid = 1'b0, CoeffValid = 1'b0, DataValid_m = 1'b0, CoeffValid_m = 1'b0;
  logic [7:0] ResultIn;
  logic       Ready, ParaLoad, SerialIn, EnableShiftAdd, ResultValid, Busy;
  logic [7:0] CoeffData, ResultOut;
  logic       Ready_m, ParaLoad_m, SerialIn_m, EnableShiftAdd_m, ResultValid_m, Busy_m;
  logic [7:0] CoeffData_m, ResultOut_m;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ResultIn = cyc[7:0] ^ 8'h5A;

  sas_serial_feeder #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
    .Clock(clk), .Reset(Reset), .DataIn(DataIn), .DataValid(DataValid),
    .CoeffIn(CoeffIn), .CoeffValid(CoeffValid), .Ready(Ready), .ParaLoad(ParaLoad),
    .CoeffData(CoeffData), .SerialIn(SerialIn), .EnableShiftAdd(EnableShiftAdd),
    .ResultIn(ResultIn), .ResultOut(ResultOut), .ResultValid(ResultValid), .Busy(Busy));

  sas_serial_feeder #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_m (
    .Clock(clk), .Reset(Reset), .DataIn(DataIn_m), .DataValid(DataValid_m),
    .CoeffIn(CoeffIn_m), .CoeffValid(CoeffValid_m), .Ready(Ready_m), .ParaLoad(ParaLoad_m),
    .CoeffData(CoeffData_m), .SerialIn(SerialIn_m), .EnableShiftAdd(EnableShiftAdd_m),
    .ResultIn(ResultIn), .ResultOut(ResultOut_m), .ResultValid(ResultValid_m), .Busy(Busy_m));

  typedef struct {
    logic [31:0] cyc;
    logic [7:0]  val;
    logic [7:0]  c;
  } ev_t;

  ev_t q_para[$], q_bit[$], q_res[$], q_bit_m[$], q_res_m[$];
  int checks = 0, errors = 0;
  logic [31:0] exp_ready = '0;
  logic [7:0]  exp_coeff = '0;
  bit          loaded_m = 1'b0;

  function automatic logic [7:0] res_at(input logic [31:0] c);
    return c[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (ParaLoad) begin
      if (q_para.size() == 0) chk("unexpected_paraload", 1, 0);
      else begin
        e = q_para.pop_front();
        chk("para_cycle", cyc, e.cyc);
        chk("para_coeff", {24'h0, CoeffData}, {24'h0, e.val});
        chk("para_busy", {Ready, Busy}, 2'b01);
      end
    end
    if (EnableShiftAdd) begin
      if (q_bit.size() == 0) chk("unexpected_shift", 1, 0);
      else begin
        e = q_bit.pop_front();
        chk("bit_cycle", cyc, e.cyc);
        chk("serial_in", {31'h0, SerialIn}, {31'h0, e.val[0]});
      end
    end else if (SerialIn) chk("serial_idle_low", 1, 0);
    if (ResultValid) begin
      if (q_res.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q_res.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("result", {24'h0, ResultOut}, {24'h0, e.val});
        chk("res_coeff", {24'h0, CoeffData}, {24'h0, e.c});
        $display("txn result=%0h coeff=%0h at cycle %0d", ResultOut, CoeffData, cyc);
      end
    end
    if (EnableShiftAdd_m) begin
      if (q_bit_m.size() == 0) chk("unexpected_shift_m", 1, 0);
      else begin
        e = q_bit_m.pop_front();
        chk("bit_cycle_m", cyc, e.cyc);
        chk("serial_in_m", {31'h0, SerialIn_m}, {31'h0, e.val[0]});
      end
    end
    if (ResultValid_m) begin
      if (q_res_m.size() == 0) chk("unexpected_result_m", 1, 0);
      else begin
        e = q_res_m.pop_front();
        chk("res_cycle_m", cyc, e.cyc);
        chk("result_m", {24'h0, ResultOut_m}, {24'h0, e.val});
        $display("txn_m result=%0h at cycle %0d", ResultOut_m, cyc);
      end
    end
  end

  task automatic wait_ready(output bit ok, output logic [31:0] a);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Ready) begin
        ok = 1'b1;
        a  = cyc;
        break;
      end
    end
    if (ok) chk("ready_cycle", a, exp_ready);
    else    chk("ready_timeout", 0, 1);
  endtask

  // Must be entered shortly after a rising edge; abort_bit < 0 means run to completion.
  task automatic do_txn(input logic [7:0] d, input logic cv, input logic [7:0] cf,
                        input bit hold, input int abort_bit);
    bit          ok, load;
    logic [31:0] a, b0, dr;
    int          nb;
    DataIn = d; CoeffIn = cf; CoeffValid = cv; DataValid = 1'b1;
    wait_ready(ok, a);
    if (!ok) begin
      DataValid = 1'b0;
      return;
    end
    load = cv || !loaded_m;
    if (cv) exp_coeff = cf;
    if (load) q_para.push_back('{a + 1, exp_coeff, 8'h00});
    loaded_m = 1'b1;
    b0 = a + 1 + {31'h0, load};
    nb = (abort_bit < 0) ? 8 : abort_bit;
    for (int i = 0; i < nb; i++) q_bit.push_back('{b0 + i, {7'h0, d[i]}, 8'h00});
    if (abort_bit < 0) begin
      dr = b0 + 8;
      q_res.push_back('{dr + 1, res_at(dr), exp_coeff});
      exp_ready = dr + 2;
    end
    $display("txn accept data=%0h cv=%0b coeff=%0h load=%0b at cycle %0d", d, cv, cf, load, a);
    @(posedge clk); #1;
    CoeffValid = 1'b0;
    if (!hold) DataValid = 1'b0;
    if (abort_bit >= 0) begin
      while (cyc != b0 + abort_bit) begin
        @(posedge clk); #1;
      end
      Reset = 1'b1;
      exp_coeff = '0;
      loaded_m  = 1'b0;
      @(negedge clk);
      chk("rst_ready_busy", {Ready, Busy}, 2'b00);
      chk("rst_coeffdata", {24'h0, CoeffData}, 0);
      @(posedge clk); #1;
      Reset = 1'b0;
      exp_ready = cyc;
      #2;
      chk("rst_resultout", {24'h0, ResultOut}, 0);
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {Ready, ParaLoad, SerialIn, EnableShiftAdd, ResultValid, Busy}, 0);
    chk("reset_coeffdata", {24'h0, CoeffData}, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    exp_ready = cyc;
    #1;
    chk("reset_resultout", {24'h0, ResultOut}, 0);

    do_txn(8'h3C, 1'b0, 8'h99, 1'b0, -1);   // first word: LOAD with coeff 00
    do_txn(8'h4D, 1'b1, 8'h56, 1'b0, -1);   // reload 56, bits 1,0,1,1,0,0,1,0
    do_txn(8'hFF, 1'b0, 8'h11, 1'b0, -1);   // no LOAD, coeff stays 56
    do_txn(8'hA5, 1'b0, 8'h00, 1'b1, -1);   // DataValid held into next word
    do_txn(8'h0F, 1'b0, 8'h00, 1'b0, -1);
    do_txn(8'hC3, 1'b0, 8'h00, 1'b0, 3);    // reset at SHIFT bit 3
    do_txn(8'h5A, 1'b0, 8'h77, 1'b0, -1);   // LOAD again with coeff 00
    repeat (15) @(posedge clk);

    #1;
    DataIn_m = 8'h80; CoeffValid_m = 1'b0; DataValid_m = 1'b1;
    ok = 1'b0; a = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Ready_m) begin
        ok = 1'b1;
        a  = cyc;
        break;
      end
    end
    if (!ok) chk("ready_timeout_m", 0, 1);
    else begin
      for (int i = 0; i < 8; i++) q_bit_m.push_back('{a + 2 + i, {7'h0, DataIn_m[7-i]}, 8'h00});
      q_res_m.push_back('{a + 11, res_at(a + 10), 8'h00});
      $display("txn_m accept data=%0h at cycle %0d", DataIn_m, a);
    end
    @(posedge clk); #1;
    DataValid_m = 1'b0;
    repeat (20) @(posedge clk);

    @(negedge clk);
    chk("q_para_empty", q_para.size(), 0);
    chk("q_bit_empty", q_bit.size(), 0);
    chk("q_res_empty", q_res.size(), 0);
    chk("q_bit_m_empty", q_bit_m.size(), 0);
    chk("q_res_m_empty", q_res_m.size(), 0);
    chk("final_coeffdata", {24'h0, CoeffData}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
